// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    COMMIT,
    DIVZ
  } mdu_state_e;

  localparam logic MDU_OP_MULT = 1'b0;
  localparam logic MDU_OP_DIV  = 1'b1;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 33;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 33;
  localparam int unsigned MDU_CNT_W_DEF       = 6;

endpackage

// File: rtl/mdu_latency_counter.sv
// Loadable down-counter that tracks the remaining engine latency.
module mdu_latency_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             cnt_is_one
);

  logic [CNT_W-1:0] cnt_q;

  // Load takes priority; decrement saturates at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences Mult/Div start pulses, latency wait, and HI/LO commit.
module muldiv_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = MDU_CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic req_div,
  input  logic divisor_zero,
  input  logic abort,
  output logic mult_start,
  output logic div_start,
  output logic hilo_sel,
  output logic hi_write,
  output logic lo_write,
  output logic busy,
  output logic done,
  output logic div_zero
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e state_q, state_d;
  logic       op_div_q, op_div_d;
  logic       cnt_load, cnt_dec, cnt_is_one;

  mdu_latency_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_val  ((op_div_q == MDU_OP_DIV) ? DIV_LOAD : MULT_LOAD),
    .dec       (cnt_dec),
    .cnt_is_one(cnt_is_one)
  );

  // State and operation-type registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_div_q <= MDU_OP_MULT;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
    end
  end

  // Next-state and Moore output decode; abort only masks the commit strobes.
  always_comb begin
    state_d    = state_q;
    op_div_d   = op_div_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    busy       = (state_q != IDLE);
    hilo_sel   = op_div_q;

    unique case (state_q)
      IDLE: begin
        if (req && !abort) begin
          op_div_d = req_div;
          state_d  = (req_div && divisor_zero) ? DIVZ : START;
        end
      end
      START: begin
        mult_start = (op_div_q == MDU_OP_MULT);
        div_start  = (op_div_q == MDU_OP_DIV);
        cnt_load   = 1'b1;
        state_d    = abort ? IDLE : RUN;
      end
      RUN: begin
        cnt_dec = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_is_one) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        hi_write = !abort;
        lo_write = !abort;
        done     = !abort;
        state_d  = IDLE;
      end
      DIVZ: begin
        div_zero = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: per-scenario expected traces derived from hand-written
// event cycles, queued when stimulus is issued and compared cycle by cycle.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset, req, req_div, divisor_zero, abort;
  logic mult_start, div_start, hilo_sel, hi_write, lo_write, busy, done, div_zero;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .MULT_CYCLES(33),
    .DIV_CYCLES (33),
    .CNT_W      (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_div     (req_div),
    .divisor_zero(divisor_zero),
    .abort       (abort),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .hilo_sel    (hilo_sel),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  // Scenario record: request at relative cycle 0, plus expected event cycles.
  typedef struct {
    string name;
    bit    op_div;
    bit    dz;
    int    abort_k;
    int    reset_k;
    int    x1;
    int    x2;
    int    len;
    int    start_c;
    bit    start_div;
    int    commit_c;
    int    busy_last;
    int    dz_c;
    bit    hilo;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];
  logic [7:0] sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(string name, bit op_div, bit dz, int abort_k, int reset_k,
                              int x1, int x2, int len, int start_c, bit start_div,
                              int commit_c, int busy_last, int dz_c, bit hilo);
    vec_t v;
    v.name = name; v.op_div = op_div; v.dz = dz; v.abort_k = abort_k;
    v.reset_k = reset_k; v.x1 = x1; v.x2 = x2; v.len = len; v.start_c = start_c;
    v.start_div = start_div; v.commit_c = commit_c; v.busy_last = busy_last;
    v.dz_c = dz_c; v.hilo = hilo;
    return v;
  endfunction

  // Packed order: mult_start div_start hilo_sel hi_write lo_write busy done div_zero
  function automatic logic [7:0] exp_vec(vec_t v, int c, bit prev_hilo);
    logic ms, ds, hs, w, b, z;
    ms = (c == v.start_c) && !v.start_div;
    ds = (c == v.start_c) && v.start_div;
    hs = (c == 0) ? prev_hilo : v.hilo;
    w  = (c == v.commit_c);
    b  = (c >= 1) && (c <= v.busy_last);
    z  = (c == v.dz_c);
    return {ms, ds, hs, w, w, b, w, z};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {mult_start, div_start, hilo_sel, hi_write, lo_write, busy, done, div_zero};
  endfunction

  task automatic check(string name, int c, logic [7:0] exp);
    logic [7:0] got;
    got = dut_vec();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s c=%0d got=%b exp=%b (ms ds sel hw lw busy done dz)", name, c, got, exp);
    end
  endtask

  initial begin
    bit prev_hilo;
    logic [7:0] e;

    //           name            op dz abt rst x1  x2 len st sd  cm  bl  dz hilo
    vecs[0]  = mk("mult",        0, 0, -1, -1, -1, -1, 35, 1, 0, 34, 34, -1, 0);
    vecs[1]  = mk("div",         1, 0, -1, -1, -1, -1, 35, 1, 1, 34, 34, -1, 1);
    vecs[2]  = mk("divz",        1, 1, -1, -1, -1, -1,  2,-1, 0, -1,  1,  1, 1);
    vecs[3]  = mk("mult_abt10",  0, 0, 10, -1, -1, -1, 11, 1, 0, -1, 10, -1, 0);
    vecs[4]  = mk("mult_xreq",   0, 0, -1, -1,  5, 34, 35, 1, 0, 34, 34, -1, 0);
    vecs[5]  = mk("div_next",    1, 0, -1, -1, -1, -1, 35, 1, 1, 34, 34, -1, 1);
    vecs[6]  = mk("div_rst20",   1, 0, -1, 20, -1, -1, 21, 1, 1, -1, 20, -1, 1);
    vecs[7]  = mk("mult_postrst",0, 0, -1, -1, -1, -1, 35, 1, 0, 34, 34, -1, 0);
    vecs[8]  = mk("mult_abt34",  0, 0, 34, -1, -1, -1, 35, 1, 0, -1, 34, -1, 0);
    vecs[9]  = mk("req_abt_same",1, 0,  0, -1, -1, -1,  3,-1, 0, -1, -1, -1, 0);
    vecs[10] = mk("divz_abt1",   1, 1,  1, -1, -1, -1,  2,-1, 0, -1,  1,  1, 1);
    vecs[11] = mk("div_abt1",    1, 0,  1, -1, -1, -1,  3, 1, 1, -1,  1, -1, 1);

    reset = 1'b1; req = 1'b0; req_div = 1'b0; divisor_zero = 1'b0; abort = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", 0, 8'h00);

    prev_hilo = 1'b0;
    for (int i = 0; i < NV; i++) begin
      for (int c = 0; c < vecs[i].len; c++) begin
        @(posedge clk);
        #1;
        reset        = (c == vecs[i].reset_k);
        abort        = (c == vecs[i].abort_k);
        req          = (c == 0) || (c == vecs[i].x1) || (c == vecs[i].x2);
        req_div      = (c == 0) ? vecs[i].op_div : 1'b1;
        divisor_zero = (c == 0) ? vecs[i].dz : 1'b0;
        if (c == 0) begin
          for (int k = 0; k < vecs[i].len; k++) sb_q.push_back(exp_vec(vecs[i], k, prev_hilo));
        end
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s c=%0d got=%b exp=<empty queue>", vecs[i].name, c, dut_vec());
        end else begin
          e = sb_q.pop_front();
          check(vecs[i].name, c, e);
        end
      end
      prev_hilo = (vecs[i].reset_k >= 0) ? 1'b0 : vecs[i].hilo;
    end

    // Idle tail: nothing pending, last op was a divide so select holds at 1.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      reset = 1'b0; abort = 1'b0; req = 1'b0; req_div = 1'b0; divisor_zero = 1'b0;
      @(negedge clk);
      check("idle_tail", c, 8'b0010_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
